// File: rtl/calc_pkg.sv
// Shared definitions for the seven-segment scanner.
// Holds the scan FSM encoding, the all-off drive levels and the active-low
// hex glyph table ({g,f,e,d,c,b,a}, 0 = segment lit).
package calc_pkg;

    localparam int unsigned VALUE_W = 16;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned SEG_W   = 7;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    localparam logic [DIGITS-1:0] AN_OFF  = 4'b1111;
    localparam logic [SEG_W-1:0]  SEG_OFF = 7'b1111111;

    // Indexed by nibble value; entry 15 is listed first.
    localparam logic [15:0][SEG_W-1:0] GLYPH_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/seg7_scan_if.sv
// Display bus bundle for the seven-segment scanner.
//   value : 16-bit word to display (driven by the data source)
//   an    : active-low digit anodes
//   seg   : active-low cathodes {g,f,e,d,c,b,a}
//   dp    : active-low decimal point
interface seg7_scan_if;
    import calc_pkg::*;

    logic [VALUE_W-1:0] value;
    logic [DIGITS-1:0]  an;
    logic [SEG_W-1:0]   seg;
    logic               dp;

    modport master (output value, input an, input seg, input dp);
    modport slave  (input value, output an, output seg, output dp);
endinterface

// File: rtl/seg7_scan_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
//   nibble  : 4-bit value 0..F
//   glyph_c : active-low {g,f,e,d,c,b,a}
module hex_to_seg7
    import calc_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] glyph_c
);

    assign glyph_c = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed four-digit seven-segment scanner.
// Each digit owns a slot of REFRESH_DIV cycles: BLANK_CYCLES of dead time to
// suppress ghosting, then the digit is lit. The displayed word is snapshotted
// only at frame boundaries so a frame never mixes two words.
//   clk   : system clock, rising edge
//   btnu  : synchronous active-high reset
//   value : 16-bit word to display
//   an    : active-low anodes, an[0] = least significant nibble
//   seg   : active-low cathodes {g,f,e,d,c,b,a}
//   dp    : active-low decimal point, held off
module seg7_scan
    import calc_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned LZ_BLANK     = 0
) (
    input  logic               clk,
    input  logic               btnu,
    input  logic [VALUE_W-1:0] value,
    output logic [DIGITS-1:0]  an,
    output logic [SEG_W-1:0]   seg,
    output logic               dp
);

    localparam int unsigned      CNT_W      = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [1:0]         dig, dig_d;
    logic [VALUE_W-1:0] snap, snap_d;
    scan_state_t        state, state_d;
    logic [DIGITS-1:0]  an_d;
    logic [SEG_W-1:0]   seg_d;
    logic [3:0]         nibble_c;
    logic [SEG_W-1:0]   glyph_c;
    logic               lead_zero_c;

    // Nibble of the snapshot belonging to the current digit.
    assign nibble_c = snap[{dig, 2'b00} +: 4];

    hex_to_seg7 u_hex (
        .nibble  (nibble_c),
        .glyph_c (glyph_c)
    );

    // True when this digit and every more significant one are zero.
    always_comb begin
        lead_zero_c = 1'b0;
        case (dig)
            2'd1:    lead_zero_c = (snap[15:4]  == 12'h000);
            2'd2:    lead_zero_c = (snap[15:8]  == 8'h00);
            2'd3:    lead_zero_c = (snap[15:12] == 4'h0);
            default: lead_zero_c = 1'b0;
        endcase
    end

    // Slot/digit/frame sequencing, FSM next state and next output drive.
    always_comb begin
        cnt_d   = cnt + CNT_W'(1);
        dig_d   = dig;
        snap_d  = snap;
        state_d = state;
        an_d    = AN_OFF;
        seg_d   = SEG_OFF;

        if (cnt == CNT_LAST) begin
            cnt_d = '0;
            dig_d = dig + 2'd1;
            if (dig == 2'd3) begin
                snap_d = value;
            end
        end

        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (cnt == CNT_LAST) begin
                    state_d = ST_BLANK;
                end
                if (!((LZ_BLANK != 0) && lead_zero_c)) begin
                    an_d      = AN_OFF;
                    an_d[dig] = 1'b0;
                    seg_d     = glyph_c;
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    // State and output registers; reset wins over wrap and capture.
    always_ff @(posedge clk) begin
        if (btnu) begin
            cnt   <= '0;
            dig   <= '0;
            snap  <= '0;
            state <= ST_BLANK;
            an    <= AN_OFF;
            seg   <= SEG_OFF;
            dp    <= 1'b1;
        end else begin
            cnt   <= cnt_d;
            dig   <= dig_d;
            snap  <= snap_d;
            state <= state_d;
            an    <= an_d;
            seg   <= seg_d;
            dp    <= 1'b1;
        end
    end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot; legal range 4..2^20.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000, anti-ghost dead time at the start of each slot; legal range 1..REFRESH_DIV-2.
REQ-003 SHALL have parameter LZ_BLANK, default 0; 1 enables leading-zero suppression.
REQ-004 SHALL have port clk, input, 1 bit, single system clock; all logic on its rising edge.
REQ-005 SHALL have port btnu, input, 1 bit, synchronous active-high reset (one clock; reset is synchronous and active-high).
REQ-006 SHALL have port value, input, 16 bits, calculator accumulator word (the calc led bus).
REQ-007 SHALL have port an, output, 4 bits, active-low digit anodes; an[0] = least significant nibble.
REQ-008 SHALL have port seg, output, 7 bits, active-low cathodes {g,f,e,d,c,b,a}.
REQ-009 SHALL have port dp, output, 1 bit, active-low decimal point; held 1 (off).

Function
REQ-010 SHALL keep a slot counter cnt (0..REFRESH_DIV-1) that increments every cycle and wraps to 0.
REQ-011 SHALL keep a digit index dig (0..3) that increments when cnt wraps and wraps 3->0.
REQ-012 SHALL capture value into snapshot snap only on the edge where cnt wraps with dig=3 (frame boundary), so one frame never mixes two words.
REQ-013 SHALL implement FSM states BLANK (cnt < BLANK_CYCLES) and SHOW (cnt >= BLANK_CYCLES); BLANK->SHOW at cnt=BLANK_CYCLES, SHOW->BLANK on cnt wrap.
REQ-014 SHALL drive an=4'b1111, seg=7'b1111111 in BLANK.
REQ-015 SHALL in SHOW drive an with only bit dig low and seg = hex glyph of snap[4*dig+3:4*dig] (0-9, A, b, C, d, E, F).
REQ-016 SHALL register an and seg; outputs reflect state (cnt, dig, snap) with exactly one cycle of latency.
REQ-017 SHALL, when LZ_BLANK=1 and dig>=1 and all nibbles dig..3 of snap are zero, hold an=4'b1111 for the whole slot; digit 0 is always shown (snap=0 shows "0").
REQ-018 SHALL ignore value changes between frame boundaries, including one on the capture edge's following cycle.

Reset
REQ-019 SHALL, while btnu=1 at a clock edge, set cnt=0, dig=0, snap=16'h0000, FSM=BLANK, an=4'b1111, seg=7'b1111111, dp=1.
REQ-020 SHALL, on reset asserted mid-slot or mid-frame, abandon the frame; the first cycle after deassertion starts slot 0 in BLANK with snap=0, with value first captured at the end of that frame.
REQ-021 SHALL give reset priority over counter wrap and snapshot capture on the same edge.

Structure
REQ-022 SHALL place the 16 active-low glyph constants and the BLANK/SHOW state encoding in the shared package calc_pkg.
REQ-023 SHALL instantiate one combinational sub-module hex_to_seg7 (4-bit nibble in, 7-bit active-low glyph out).
REQ-024 SHALL have no clock divider or derived clock; slot timing uses the cnt enable only.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-025 SHALL cover: reset, value=16'h1234, run 1 frame -> every slot shows glyph 0 on digits 0..3; next frame slots show 4,3,2,1 on an=1110,1101,1011,0111, and each slot has 2 blank cycles then 6 lit cycles.
REQ-026 SHALL cover: value changes 16'h0FF0->16'h324F mid-frame -> the current frame shows 0FF0 intact; 324F appears from the next frame.
REQ-027 SHALL cover: value=16'hFFFF -> seg=7'b0001110 (F) on all four digits; value=16'h2D31 -> d shows 7'b0100001.
REQ-028 SHALL cover: LZ_BLANK=1, value=16'h0004 -> only an[0] ever goes low (glyph 4 = 7'b0011001); value=16'h0000 -> digit 0 shows 7'b1000000.
REQ-029 SHALL cover: btnu pulsed on cycle 5 of slot 2 -> next cycle an=1111, seg=1111111; after release, slot 0 starts with 2 blank cycles and snap=0.
